seg_scan_decoder: RTL and testbench

//  Reader side of the 8-digit multiplexed 7-segment interface (SEL/SEG) driven by electric_clock.

---
 rtl/seg_scan_decoder.sv | 171 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: reads back an 8-digit multiplexed 7-segment scan bus.
// It waits for each digit to settle, then decodes it to a hex nibble. It
// assembles complete frames and flags illegal or undecodable digits.
module seg_scan_decoder #(
  parameter int STABLE_CNT    = 16,
  parameter int SEL_ACT_LOW   = 1,
  parameter int SEG_ACT_LOW   = 1,
  parameter int FRAME_TIMEOUT = 1_000_000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  SEL,
  input  logic [7:0]  SEG,
  output logic [31:0] Digits,
  output logic [7:0]  Dp,
  output logic [7:0]  Blank,
  output logic        Frame_valid,
  output logic        Seg_err,
  output logic        Stale,
  output logic [7:0]  Err_cnt
);

  localparam int SCW = (STABLE_CNT > 2) ? $clog2(STABLE_CNT) : 1;
  localparam logic [SCW-1:0] SC_MAX = SCW'(STABLE_CNT - 1);
  localparam int TOW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [TOW-1:0] TO_MAX = TOW'(FRAME_TIMEOUT);
  // Sampler reset value is the idle (nothing selected, all segments off) bus level.
  localparam logic [7:0] SEL_IDLE = (SEL_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [7:0] SEG_IDLE = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

  logic [7:0]     sel_s1, sel_s2, seg_s1, seg_s2;
  logic [7:0]     sel_n, seg_n;
  logic [15:0]    cur_bus, prev_bus;
  logic [SCW-1:0] stab_cnt;
  logic           committed;
  logic [7:0]     seen;
  logic [TOW-1:0] to_cnt;

  logic           commit;
  logic [7:0]     c_sel, c_seg;
  logic           onehot;
  logic [2:0]     idx;
  logic [4:0]     dec;
  logic           is_blank;
  logic           legal;
  logic           err_set;
  logic           frame_set;

  // Map active-high gfedcba to {valid, nibble}.
  function automatic logic [4:0] decode_seg(input logic [6:0] p);
    logic [4:0] r;
    r = 5'h00;
    case (p)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h07: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h6F: r = 5'h19;
      7'h77: r = 5'h1A;
      7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;
      7'h5E: r = 5'h1D;
      7'h79: r = 5'h1E;
      7'h71: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  assign sel_n   = (SEL_ACT_LOW != 0) ? ~sel_s2 : sel_s2;
  assign seg_n   = (SEG_ACT_LOW != 0) ? ~seg_s2 : seg_s2;
  assign cur_bus = {sel_n, seg_n};
  assign Stale   = (to_cnt == TO_MAX);

  // Two-flop sampler on the asynchronous scan bus.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sel_s1 <= SEL_IDLE;
      sel_s2 <= SEL_IDLE;
      seg_s1 <= SEG_IDLE;
      seg_s2 <= SEG_IDLE;
    end else begin
      sel_s1 <= SEL;
      sel_s2 <= sel_s1;
      seg_s1 <= SEG;
      seg_s2 <= seg_s1;
    end
  end

  // Stability tracking. prev_bus holds the value being timed. The commit
  // uses it so that a change arriving on the commit cycle cannot corrupt
  // the digit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_bus  <= '0;
      stab_cnt  <= '0;
      committed <= 1'b0;
    end else begin
      prev_bus <= cur_bus;
      if (cur_bus != prev_bus) begin
        stab_cnt  <= '0;
        committed <= 1'b0;
      end else begin
        if (stab_cnt != SC_MAX) stab_cnt <= stab_cnt + SCW'(1);
        if (commit) committed <= 1'b1;
      end
    end
  end

  // Commit classification: blanking gap, multi-hot select, decodable or blank digit.
  always_comb begin
    commit    = (stab_cnt == SC_MAX) && !committed;
    c_sel     = prev_bus[15:8];
    c_seg     = prev_bus[7:0];
    onehot    = (c_sel != 8'h00) && ((c_sel & (c_sel - 8'h01)) == 8'h00);
    idx       = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (c_sel[i]) idx = 3'(i);
    end
    dec       = decode_seg(c_seg[6:0]);
    is_blank  = (c_seg[6:0] == 7'h00);
    legal     = commit && onehot && (dec[4] || is_blank);
    err_set   = commit && (c_sel != 8'h00) && !(onehot && (dec[4] || is_blank));
    frame_set = legal && ((seen | c_sel) == 8'hFF);
  end

  // Digit, blank, decimal-point, frame and error bookkeeping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Digits      <= '0;
      Dp          <= '0;
      Blank       <= 8'hFF;
      seen        <= '0;
      Frame_valid <= 1'b0;
      Seg_err     <= 1'b0;
      Err_cnt     <= '0;
    end else begin
      Frame_valid <= frame_set;
      Seg_err     <= err_set;
      if (err_set && (Err_cnt != 8'hFF)) Err_cnt <= Err_cnt + 8'd1;
      if (commit && onehot) Dp[idx] <= c_seg[7];
      if (legal) begin
        if (dec[4]) begin
          Digits[4*idx +: 4] <= dec[3:0];
          Blank[idx]         <= 1'b0;
        end else begin
          Blank[idx] <= 1'b1;
        end
        seen <= frame_set ? 8'h00 : (seen | c_sel);
      end
    end
  end

  // Frame timeout. It clears on the same edge that raises Frame_valid, so
  // Stale is already low in the pulse cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      to_cnt <= '0;
    end else if (frame_set) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + TOW'(1);
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (STABLE_CNT=16, active-low bus, FRAME_TIMEOUT=100).
module tb_seg_scan_decoder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [7:0]  SEL, SEG;
  logic [31:0] Digits;
  logic [7:0]  Dp, Blank, Err_cnt;
  logic        Frame_valid, Seg_err, Stale;

  int n_cmp = 0;
  int n_fail = 0;
  int fv_cnt = 0;
  int err_pulses = 0;
  int fv_stale = 0;
  int w;

  logic [7:0] seg_al [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_scan_decoder #(
    .STABLE_CNT(16), .SEL_ACT_LOW(1), .SEG_ACT_LOW(1), .FRAME_TIMEOUT(100)
  ) dut (
    .Clk(Clk), .Reset(Reset), .SEL(SEL), .SEG(SEG),
    .Digits(Digits), .Dp(Dp), .Blank(Blank), .Frame_valid(Frame_valid),
    .Seg_err(Seg_err), .Stale(Stale), .Err_cnt(Err_cnt)
  );

  always #5 Clk = ~Clk;

  // Pulse monitor sampled away from the active edge.
  always @(negedge Clk) begin
    if (Frame_valid) begin
      fv_cnt++;
      if (Stale) fv_stale++;
    end
    if (Seg_err) err_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives the bus and holds it for n rising edges.
  task automatic hold(input logic [7:0] s, input logic [7:0] g, input int n);
    SEL = s;
    SEG = g;
    repeat (n) @(negedge Clk);
  endtask

  function automatic logic [7:0] sel_of(input int i);
    return ~(8'h01 << i);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    SEL = 8'hFF;
    SEG = 8'hFF;
    @(negedge Clk);
    repeat (5) @(negedge Clk);
    check("rst_digits", Digits, 32'h0);
    check("rst_blank", {24'h0, Blank}, 32'hFF);
    check("rst_dp", {24'h0, Dp}, 32'h0);
    check("rst_fv", {31'h0, Frame_valid}, 32'h0);
    check("rst_err", {31'h0, Seg_err}, 32'h0);
    check("rst_stale", {31'h0, Stale}, 32'h0);
    check("rst_errcnt", {24'h0, Err_cnt}, 32'h0);
    Reset = 1'b0;
    hold(8'hFF, 8'hFF, 20);

    // Full frame 0..7
    for (int i = 0; i < 8; i++) hold(sel_of(i), seg_al[i], 40);
    hold(8'hFF, 8'hFF, 30);
    check("frame1_count", fv_cnt, 1);
    check("frame1_digits", Digits, 32'h7654_3210);
    check("frame1_dp", {24'h0, Dp}, 32'h0);
    check("frame1_blank", {24'h0, Blank}, 32'h0);
    check("frame1_noerr", err_pulses, 0);
    check("frame1_stale", {31'h0, Stale}, 32'h0);

    // Glitch: 15 stable cycles must not commit, 16 must
    hold(sel_of(3), seg_al[9], 15);
    hold(8'hFF, 8'hFF, 30);
    check("glitch_kept", {28'h0, Digits[15:12]}, 32'h3);
    hold(sel_of(3), seg_al[9], 16);
    hold(8'hFF, 8'hFF, 30);
    check("stable16_commit", {28'h0, Digits[15:12]}, 32'h9);
    hold(sel_of(5), 8'h12, 40);
    hold(8'hFF, 8'hFF, 30);
    check("dp5_set", {24'h0, Dp}, 32'h20);
    check("dp5_digits", Digits, 32'h7654_9210);
    check("no_repulse", fv_cnt, 1);

    // Multi-hot select, then blank digit 0
    hold(8'hFC, 8'hC0, 40);
    hold(8'hFF, 8'hFF, 30);
    check("multihot_pulse", err_pulses, 1);
    check("multihot_errcnt", {24'h0, Err_cnt}, 32'h1);
    hold(8'hFE, 8'hFF, 40);
    hold(8'hFF, 8'hFF, 30);
    check("blank0", {24'h0, Blank}, 32'h01);
    check("blank0_noerr", {24'h0, Err_cnt}, 32'h1);
    check("blank0_digits", Digits, 32'h7654_9210);

    // Undecodable pattern on digit 2, then saturate the error counter
    hold(8'hFB, 8'h55, 40);
    hold(8'hFF, 8'hFF, 30);
    check("undec_errcnt", {24'h0, Err_cnt}, 32'h2);
    check("undec_digits", Digits, 32'h7654_9210);
    check("undec_blank", {24'h0, Blank}, 32'h01);
    check("idle_stale", {31'h0, Stale}, 32'h1);
    for (int k = 0; k < 300; k++) hold(8'hFB, (k % 2 == 1) ? 8'hAA : 8'h55, 20);
    hold(8'hFF, 8'hFF, 30);
    check("errcnt_sat", {24'h0, Err_cnt}, 32'hFF);
    check("err_pulses", err_pulses, 302);
    check("sat_digits", Digits, 32'h7654_9210);

    // Timeout: frame of 8..F, then Stale after exactly 100 cycles
    for (int i = 0; i < 7; i++) hold(sel_of(i), seg_al[8 + i], 40);
    check("pre_frame_stale", {31'h0, Stale}, 32'h1);
    SEL = sel_of(7);
    SEG = seg_al[15];
    w = 0;
    while (!Frame_valid && w < 60) begin
      @(negedge Clk);
      w++;
    end
    check("frame2_seen", {31'h0, Frame_valid}, 32'h1);
    check("stale_at_fv", {31'h0, Stale}, 32'h0);
    SEL = 8'hFF;
    SEG = 8'hFF;
    repeat (99) @(negedge Clk);
    check("stale_99", {31'h0, Stale}, 32'h0);
    @(negedge Clk);
    check("stale_100", {31'h0, Stale}, 32'h1);
    check("frame2_digits", Digits, 32'hFEDC_BA98);
    check("frame2_count", fv_cnt, 2);
    check("fv_never_stale", fv_stale, 0);

    // Reset after 4 digits discards the partial frame
    for (int i = 0; i < 4; i++) hold(sel_of(i), seg_al[i], 40);
    Reset = 1'b1;
    hold(8'hFF, 8'hFF, 3);
    check("midrst_digits", Digits, 32'h0);
    check("midrst_blank", {24'h0, Blank}, 32'hFF);
    check("midrst_errcnt", {24'h0, Err_cnt}, 32'h0);
    check("midrst_stale", {31'h0, Stale}, 32'h0);
    Reset = 1'b0;
    for (int i = 4; i < 8; i++) hold(sel_of(i), seg_al[i], 40);
    hold(8'hFF, 8'hFF, 30);
    check("half_no_frame", fv_cnt, 2);
    for (int i = 0; i < 4; i++) hold(sel_of(i), seg_al[i], 40);
    hold(8'hFF, 8'hFF, 30);
    check("after_rst_frame", fv_cnt, 3);
    check("after_rst_digits", Digits, 32'h7654_3210);
    check("after_rst_blank", {24'h0, Blank}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
